// File: rtl/johnson_decode_if.sv
// Bus between a Johnson-code source and johnson_decode: sample strobe, code word and
// error-counter clear going in; decoded index, lock status and error pulses coming out.
interface johnson_decode_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic [3:0]       jin;
    logic             clr;
    logic [2:0]       idx;
    logic             valid;
    logic             locked;
    logic             seq_err;
    logic             code_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, jin, clr,
        input  idx, valid, locked, seq_err, code_err, err_cnt
    );

    modport slave (
        input  en, jin, clr,
        output idx, valid, locked, seq_err, code_err, err_cnt
    );
endinterface

// File: rtl/johnson_decode.sv
// Decodes a 4-bit Johnson counter word to its index and tracks HUNT/CHECK/LOCKED sequencing.
// Define JOHNSON_DECODE_ERRCNT_EN to build the saturating error counter (else err_cnt is tied to 0).
module johnson_decode #(
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    johnson_decode_if.slave        bus
);
    typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [2:0] LOCK_N = LOCK_CNT[2:0];

    state_t     r_state, w_state_nxt;
    logic [2:0] r_good, w_good_nxt, w_good_inc;
    logic [2:0] r_idx, w_idx_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_locked, w_locked_nxt;
    logic       r_seq_err, w_seq_err_nxt;
    logic       r_code_err, w_code_err_nxt;
    logic       w_legal;
    logic [2:0] w_dec;
    logic       w_repeat, w_succ;

    always_comb begin
        w_legal = 1'b1;
        w_dec   = 3'd0;
        case (bus.jin)
            4'b0000: w_dec = 3'd0;
            4'b1000: w_dec = 3'd1;
            4'b1100: w_dec = 3'd2;
            4'b1110: w_dec = 3'd3;
            4'b1111: w_dec = 3'd4;
            4'b0111: w_dec = 3'd5;
            4'b0011: w_dec = 3'd6;
            4'b0001: w_dec = 3'd7;
            default: w_legal = 1'b0;
        endcase
    end

    // 3-bit compare so 7 -> 0 counts as a successor
    assign w_repeat   = (w_dec == r_idx);
    assign w_succ     = (w_dec == r_idx + 3'd1);
    assign w_good_inc = r_good + 3'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= HUNT;
            r_good     <= 3'd0;
            r_idx      <= 3'd0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_seq_err  <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good     <= w_good_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_locked   <= w_locked_nxt;
            r_seq_err  <= w_seq_err_nxt;
            r_code_err <= w_code_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (bus.en) begin
            if (!w_legal) begin
                w_state_nxt = HUNT;
                w_good_nxt  = 3'd0;
            end else begin
                case (r_state)
                    HUNT: begin
                        w_state_nxt = CHECK;
                        w_good_nxt  = 3'd0;
                    end
                    CHECK: begin
                        if (w_repeat) begin
                            w_good_nxt = r_good;
                        end else if (w_succ) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc >= LOCK_N)
                                w_state_nxt = LOCKED;
                        end else begin
                            w_good_nxt = 3'd0;
                        end
                    end
                    LOCKED: begin
                        if (!w_repeat && !w_succ) begin
                            w_state_nxt = CHECK;
                            w_good_nxt  = 3'd0;
                        end
                    end
                    default: begin
                        w_state_nxt = HUNT;
                        w_good_nxt  = 3'd0;
                    end
                endcase
            end
        end
    end

    // A repeat decodes to the current idx, so loading w_dec on every legal code is a hold for it
    always_comb begin
        w_idx_nxt      = r_idx;
        w_valid_nxt    = r_valid;
        w_locked_nxt   = r_locked;
        w_seq_err_nxt  = 1'b0;
        w_code_err_nxt = 1'b0;
        if (bus.en) begin
            if (!w_legal) begin
                w_code_err_nxt = 1'b1;
                w_valid_nxt    = 1'b0;
                w_locked_nxt   = 1'b0;
            end else begin
                w_idx_nxt     = w_dec;
                w_valid_nxt   = 1'b1;
                w_locked_nxt  = (w_state_nxt == LOCKED);
                w_seq_err_nxt = (r_state == LOCKED) && (w_state_nxt == CHECK);
            end
        end
    end

    assign bus.idx      = r_idx;
    assign bus.valid    = r_valid;
    assign bus.locked   = r_locked;
    assign bus.seq_err  = r_seq_err;
    assign bus.code_err = r_code_err;

`ifdef JOHNSON_DECODE_ERRCNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.clr)
            r_err_cnt <= '0;
        else if ((w_seq_err_nxt || w_code_err_nxt) && (r_err_cnt != {ERR_W{1'b1}}))
            r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end

    assign bus.err_cnt = r_err_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = bus.clr;
    assign bus.err_cnt  = '0;
`endif
endmodule

// File: tb/tb_johnson_decode.sv
// Directed-vector bench for johnson_decode (LOCK_CNT=2, ERR_W=2); each row gives inputs and
// the expected registered outputs one edge later.
module tb_johnson_decode;
`ifdef JOHNSON_DECODE_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       r;
        logic       e;
        logic [3:0] j;
        logic       c;
        logic [2:0] idx;
        logic       v;
        logic       l;
        logic       se;
        logic       ce;
        logic [1:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    johnson_decode_if #(.ERR_W(2)) bus ();

    johnson_decode #(.LOCK_CNT(2), .ERR_W(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t t);
        rst     = t.r;
        bus.en  = t.e;
        bus.jin = t.j;
        bus.clr = t.c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] got_v();
        return {bus.idx, bus.valid, bus.locked, bus.seq_err, bus.code_err, bus.err_cnt};
    endfunction

    // err_cnt is expected to read 0 when the counter is not built
    function automatic logic [8:0] exp_v(input vec_t t);
        return {t.idx, t.v, t.l, t.se, t.ce, (CNT_EN ? t.cnt : 2'd0)};
    endfunction

    task automatic test_reset();
        vec_t tv [2];
        tv = '{ '{1'b1,1'b1,4'b1000,1'b0, 3'd0,1'b0,1'b0,1'b0,1'b0,2'd0},
                '{1'b1,1'b0,4'b0000,1'b1, 3'd0,1'b0,1'b0,1'b0,1'b0,2'd0} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL reset[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    task automatic test_lock_wrap();
        vec_t tv [9];
        tv = '{ '{1'b0,1'b1,4'b0000,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1000,1'b0, 3'd1,1'b1,1'b0,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1100,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1110,1'b0, 3'd3,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b0111,1'b0, 3'd5,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b0011,1'b0, 3'd6,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b0001,1'b0, 3'd7,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b0000,1'b0, 3'd0,1'b1,1'b1,1'b0,1'b0,2'd0} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL lock_wrap[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    task automatic test_illegal();
        vec_t tv [4];
        tv = '{ '{1'b0,1'b1,4'b1000,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1010,1'b0, 3'd1,1'b0,1'b0,1'b0,1'b1,2'd1},
                '{1'b0,1'b1,4'b1100,1'b0, 3'd2,1'b1,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b0,4'b1010,1'b0, 3'd2,1'b1,1'b0,1'b0,1'b0,2'd1} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL illegal[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    task automatic test_seq_err();
        vec_t tv [11];
        tv = '{ '{1'b0,1'b1,4'b0011,1'b0, 3'd6,1'b1,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b0011,1'b0, 3'd6,1'b1,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b0001,1'b0, 3'd7,1'b1,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b0000,1'b0, 3'd0,1'b1,1'b1,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b1000,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b1100,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b1110,1'b0, 3'd3,1'b1,1'b1,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b0011,1'b0, 3'd6,1'b1,1'b0,1'b1,1'b0,2'd2},
                '{1'b0,1'b1,4'b0011,1'b0, 3'd6,1'b1,1'b0,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b0001,1'b0, 3'd7,1'b1,1'b0,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b0000,1'b0, 3'd0,1'b1,1'b1,1'b0,1'b0,2'd2} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL seq_err[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    task automatic test_hold_strobe();
        vec_t tv [12];
        tv = '{ '{1'b0,1'b1,4'b1000,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1100,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1110,1'b0, 3'd3,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b0,4'b0111,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b0,4'b1010,1'b0, 3'd4,1'b1,1'b1,1'b0,1'b0,2'd2},
                '{1'b0,1'b1,4'b0111,1'b0, 3'd5,1'b1,1'b1,1'b0,1'b0,2'd2} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL hold_strobe[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    task automatic test_sat_clr();
        vec_t tv [8];
        tv = '{ '{1'b0,1'b0,4'b0000,1'b1, 3'd5,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1010,1'b0, 3'd5,1'b0,1'b0,1'b0,1'b1,2'd1},
                '{1'b0,1'b1,4'b0101,1'b0, 3'd5,1'b0,1'b0,1'b0,1'b1,2'd2},
                '{1'b0,1'b1,4'b1001,1'b0, 3'd5,1'b0,1'b0,1'b0,1'b1,2'd3},
                '{1'b0,1'b1,4'b0100,1'b0, 3'd5,1'b0,1'b0,1'b0,1'b1,2'd3},
                '{1'b0,1'b1,4'b1011,1'b0, 3'd5,1'b0,1'b0,1'b0,1'b1,2'd3},
                '{1'b0,1'b1,4'b1101,1'b1, 3'd5,1'b0,1'b0,1'b0,1'b1,2'd0},
                '{1'b0,1'b1,4'b0111,1'b0, 3'd5,1'b1,1'b0,1'b0,1'b0,2'd0} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL sat_clr[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    task automatic test_reset_midrun();
        vec_t tv [10];
        tv = '{ '{1'b0,1'b1,4'b0011,1'b0, 3'd6,1'b1,1'b0,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b0001,1'b0, 3'd7,1'b1,1'b1,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1010,1'b0, 3'd7,1'b0,1'b0,1'b0,1'b1,2'd1},
                '{1'b0,1'b1,4'b0001,1'b0, 3'd7,1'b1,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b0000,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,2'd1},
                '{1'b0,1'b1,4'b1000,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,2'd1},
                '{1'b1,1'b1,4'b1100,1'b0, 3'd0,1'b0,1'b0,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1110,1'b0, 3'd3,1'b1,1'b0,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b1111,1'b0, 3'd4,1'b1,1'b0,1'b0,1'b0,2'd0},
                '{1'b0,1'b1,4'b0111,1'b0, 3'd5,1'b1,1'b1,1'b0,1'b0,2'd0} };
        foreach (tv[i]) begin
            drive(tv[i]);
            checks++;
            if (got_v() !== exp_v(tv[i])) begin
                errors++;
                $display("FAIL reset_midrun[%0d] idx,v,l,se,ce,cnt got %b want %b", i, got_v(), exp_v(tv[i]));
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.jin = 4'b0000;
        bus.clr = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_lock_wrap();
        test_illegal();
        test_seq_err();
        test_hold_strobe();
        test_sat_clr();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/johnson_decode.md
JOHNSON_DECODE -- requirements
Module: johnson_decode

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 2: the number of consecutive correct successor samples needed to enter LOCKED (range 1..7).
REQ-002 The block SHALL have parameter ERR_W, default 8: the width of err_cnt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  sample strobe; jin is evaluated only on cycles with en=1.
REQ-006 jin  input  4  Johnson-coded word from a 4-bit Johnson counter.
REQ-007 clr  input  1  synchronous clear of err_cnt.
REQ-008 idx  output  3  decoded index 0..7 of the last accepted valid code.
REQ-009 valid  output  1  high while idx holds a decoded valid code.
REQ-010 locked  output  1  high in the LOCKED state.
REQ-011 seq_err  output  1  one-cycle pulse: a valid code arrived out of sequence.
REQ-012 code_err  output  1  one-cycle pulse: an illegal code arrived.
REQ-013 err_cnt  output  ERR_W  saturating error count.

Function
REQ-014 The decode SHALL be: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7 (jin[3:0] shown MSB first).
- All other 8 codes SHALL be illegal.
REQ-015 All outputs SHALL be registered, with a latency of 1 clk from the en=1 sample to the output update.
REQ-016 When en=0, the state, idx, valid and locked SHALL hold, and seq_err=code_err=0 on the next cycle.
REQ-017 The FSM SHALL have the states HUNT, CHECK and LOCKED.
REQ-018 HUNT + valid code -> CHECK: idx=decode, valid=1, good=0.
REQ-019 In any state, an illegal code SHALL set code_err=1, valid=0 and locked=0, and the FSM SHALL go to HUNT.
- idx holds its old value.
REQ-020 A successor SHALL be defined as decode == (idx+1) mod 8; the 7->0 wrap SHALL be legal.
REQ-021 A repeat (decode == idx) SHALL be a hold.
- No error; idx, state and good are unchanged.
REQ-022 CHECK + successor: idx updates and good increments.
- When good reaches LOCK_CNT -> LOCKED, and locked=1 on the same output update.
REQ-023 CHECK + other valid code (neither repeat nor successor): idx=decode and good=0.
- Stays in CHECK; no seq_err (not yet locked).
REQ-024 LOCKED + successor: idx updates and the FSM stays LOCKED.
REQ-025 LOCKED + other valid code: seq_err=1, locked=0, idx=decode, good=0 -> CHECK.
REQ-026 seq_err and code_err SHALL be mutually exclusive and high for exactly one cycle per offending sample.
REQ-027 err_cnt SHALL increment by 1 on each seq_err or code_err event and saturate at 2^ERR_W-1.
REQ-028 When clr=1, err_cnt SHALL become 0 on the next edge.
- clr wins over a simultaneous error event.

Reset
REQ-029 rst=1 SHALL force: FSM=HUNT, good=0, idx=0, valid=0, locked=0, seq_err=0, code_err=0, err_cnt=0.
- rst overrides en and clr.
REQ-030 rst asserted mid-sequence SHALL discard all history; the first valid code after rst releases enters CHECK per REQ-018.

Configuration
REQ-031 The error counter SHALL be controlled by the macro JOHNSON_DECODE_ERRCNT_EN.
- Defined: err_cnt and clr behave per REQ-027/REQ-028.
- Undefined: no counter register; err_cnt is tied to 0 and clr is ignored.
- All other behaviour is identical in both cases.

Verification
REQ-032 The bench SHALL cover the following scenarios:
- Lock and wrap: rst, then en=1 with jin=0000,1000,1100,1110,...,0001,0000 -> locked=1 after the 3rd sample's update (LOCK_CNT=2); idx tracks 0..7,0; no errors.
- Illegal code: while LOCKED, jin=1010 -> next cycle code_err=1, valid=0, locked=0, err_cnt=1; then 1100 -> CHECK with idx=2.
- Sequence error: while LOCKED at idx=3, jin=0011 -> seq_err=1, idx=6, locked=0, err_cnt increments.
- Hold and strobe: LOCKED at idx=4; repeat jin=1111 for 5 cycles with en=1, then jin=0111 with en=0 -> idx stays 4, locked stays 1, no pulses.
- Saturation/clr (macro defined, ERR_W=2): 5 illegal codes -> err_cnt=3; clr together with an illegal code -> err_cnt=0 while code_err=1.
- Reset mid-run: rst while LOCKED -> all outputs 0 on the next edge; macro undefined -> err_cnt stays 0 throughout.
